uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage: the downstream counterpart of the transmitter, consuming its `tx` line. It recovers 8N1 frames (start bit 0, eight data bits LSB first, stop bit 1) by mid-bit sampling, and validates start and stop bits. Each received byte is held in a one-entry output register with a valid/ack handshake toward the game-logic consumer, with framing-error and overrun reporting.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_receiver_if.sv | 37 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_receiver.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
//
// Purpose: one place for the 8N1 frame shape and the receiver FSM states,
// so the receiver, its bus interface and the bench agree on widths.
// Ports: none (package).

package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 16;

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [DATA_BITS-1:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_RECOVER
  } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - byte handshake between the UART receiver and its consumer
//
// Purpose: groups the received-byte holding register, its valid/ack handshake
// and the error/overrun flags.
// Signals:
//   rxdata   receiver -> consumer  last accepted byte
//   rxvalid  receiver -> consumer  byte available (level)
//   rxack    consumer -> receiver  one-cycle acknowledge
//   rxerror  receiver -> consumer  one-cycle framing-error pulse
//   overrun  receiver -> consumer  sticky, a byte was dropped
// Modports: master = receiver side, slave = consumer side.

interface uart_receiver_if;

  logic [uart_pkg::DATA_BITS-1:0] rxdata;
  logic                           rxvalid;
  logic                           rxack;
  logic                           rxerror;
  logic                           overrun;

  modport master (
    output rxdata,
    output rxvalid,
    output rxerror,
    output overrun,
    input  rxack
  );

  modport slave (
    input  rxdata,
    input  rxvalid,
    input  rxerror,
    input  overrun,
    output rxack
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
//
// Purpose: brings an asynchronous level (serial line, button) into the
// clock domain. Both flops reset to RESET_VALUE so an idle line does not
// look like an edge after reset.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous, active-high
//   d      in   asynchronous input
//   q      out  synchronized output, two clocks of latency

module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with one-entry output register
//
// Purpose: recovers start / 8 data (LSB first) / stop frames by mid-bit
// sampling, checks start and stop bits, and hands each byte to the consumer
// through a valid/ack holding register with overrun and framing-error flags.
// Parameters:
//   clockperbit  clocks per bit period (4..65535), must match the transmitter
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-high
//   rx      in   serial line, asynchronous, idles high
//   rx_bus  master side of uart_receiver_if (rxdata/rxvalid/rxack/rxerror/overrun)

module uart_receiver
  import uart_pkg::*;
#(
  parameter int clockperbit = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx,
  uart_receiver_if.master rx_bus
);

  // Start bit is checked half a bit after the falling edge; every later
  // sample is a whole bit further on.
  localparam cnt_t HALF_LOAD = cnt_t'(clockperbit / 2 - 1);
  localparam cnt_t BIT_LOAD  = cnt_t'(clockperbit - 1);

  logic      rxs;
  rx_state_t state;
  cnt_t      count;
  logic [2:0] bit_idx;
  byte_t     shift_reg;
  byte_t     rxdata_q;
  logic      rxvalid_q;
  logic      rxerror_q;
  logic      overrun_q;

  logic stop_sample;
  logic deliver;
  logic ack_take;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rxs)
  );

  assign stop_sample = (state == ST_STOP) && (count == '0);
  assign deliver     = stop_sample && rxs;
  assign ack_take    = rx_bus.rxack && rxvalid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rxdata_q  <= '0;
      rxvalid_q <= 1'b0;
      rxerror_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rxerror_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            count <= HALF_LOAD;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (count != '0) begin
            count <= count - cnt_t'(1);
          end else if (!rxs) begin
            count   <= BIT_LOAD;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            // Line back high at mid start bit: a glitch, not a frame.
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (count != '0) begin
            count <= count - cnt_t'(1);
          end else begin
            shift_reg[bit_idx] <= rxs;
            count              <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (count != '0) begin
            count <= count - cnt_t'(1);
          end else if (rxs) begin
            // Back to IDLE at the stop midpoint so a short stop bit
            // does not cost the next frame.
            state <= ST_IDLE;
          end else begin
            rxerror_q <= 1'b1;
            state     <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          // Wait out a break so it produces only one error.
          if (rxs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Holding register: an ack in the delivery cycle frees the slot for
      // the new byte; otherwise a byte arriving on a full slot is dropped.
      if (deliver) begin
        if (!rxvalid_q || rx_bus.rxack) begin
          rxdata_q  <= shift_reg;
          rxvalid_q <= 1'b1;
          overrun_q <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (ack_take) begin
        rxvalid_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_bus.rxdata  = rxdata_q;
  assign rx_bus.rxvalid = rxvalid_q;
  assign rx_bus.rxerror = rxerror_q;
  assign rx_bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver

module tb_uart_receiver;

  localparam int N = 10;
  localparam int H = N / 2;

  typedef struct {
    int         at_cyc;
    logic [7:0] data;
    bit         ok;
  } ev_t;

  logic clock;
  logic reset;
  logic rx;

  uart_receiver_if bus ();

  uart_receiver #(
    .clockperbit(N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .rx_bus(bus.master)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_at = -10;
  bit ack_rand = 0;
  bit chk_en = 0;
  int err_pulses = 0;

  ev_t evq[$];
  logic       m_valid = 0;
  logic [7:0] m_data = 0;
  logic       m_err = 0;
  logic       m_ovr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial clock = 0;
  always #5 clock = ~clock;

  // Reference model: a frame whose start bit is first captured at edge E0
  // completes at E0+2+H+9N; the holding register follows the handshake rules.
  always @(posedge clock) begin
    ev_t ev;
    cyc++;
    if (reset) begin
      evq.delete();
      m_valid = 0;
      m_data  = 0;
      m_err   = 0;
      m_ovr   = 0;
    end else begin
      m_err = 0;
      if (evq.size() > 0 && evq[0].at_cyc == cyc) begin
        ev = evq.pop_front();
        if (!ev.ok) begin
          m_err = 1;
        end else if (!m_valid || bus.rxack) begin
          m_data  = ev.data;
          m_valid = 1;
          m_ovr   = 0;
        end else begin
          m_ovr = 1;
        end
      end else if (bus.rxack && m_valid) begin
        m_valid = 0;
        m_ovr   = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("rxvalid", bus.rxvalid, m_valid);
      check("rxdata", bus.rxdata, m_data);
      check("rxerror", bus.rxerror, m_err);
      check("overrun", bus.overrun, m_ovr);
      if (bus.rxerror) err_pulses++;
    end
  end

  // Consumer: scheduled single acks plus optional random acks.
  initial begin
    bus.rxack = 0;
    forever begin
      @(negedge clock);
      #1;
      bus.rxack = (cyc + 1 == ack_at) || (ack_rand && ($urandom % 4 == 0));
    end
  end

  task automatic idle(input int n);
    rx = 1;
    repeat (n) @(negedge clock);
  endtask

  task automatic ack_once();
    ack_at = cyc + 1;
    @(negedge clock);
  endtask

  task automatic glitch(input int len);
    rx = 0;
    repeat (len) @(negedge clock);
    rx = 1;
    repeat (2 * N) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_len,
                            input int abort_bit);
    ev_t ev;
    if (abort_bit < 0) begin
      ev.at_cyc = cyc + 1 + 2 + H + 9 * N;
      ev.data   = d;
      ev.ok     = stop_ok;
      evq.push_back(ev);
    end
    rx = 0;
    repeat (N) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      if (k == abort_bit) begin
        repeat (N / 2) @(negedge clock);
        #2 reset = 1;
        repeat (3) @(negedge clock);
        check("abort_rxvalid", bus.rxvalid, 0);
        check("abort_rxdata", bus.rxdata, 0);
        check("abort_rxerror", bus.rxerror, 0);
        check("abort_overrun", bus.overrun, 0);
        #2 reset = 0;
        rx = 1;
        return;
      end
      repeat (N) @(negedge clock);
    end
    rx = stop_ok;
    repeat (stop_len) @(negedge clock);
  endtask

  initial begin
    int e0;
    logic [7:0] b;
    rx    = 1;
    reset = 1;
    repeat (3) @(negedge clock);
    check("reset_rxvalid", bus.rxvalid, 0);
    check("reset_rxdata", bus.rxdata, 0);
    check("reset_rxerror", bus.rxerror, 0);
    check("reset_overrun", bus.overrun, 0);
    #2 reset = 0;
    chk_en = 1;
    @(negedge clock);

    // Single byte and its latency (model tracks the 97-edge delivery).
    send_frame(8'hA5, 1, N, -1);
    idle(5);
    check("a5_rxdata", bus.rxdata, 8'hA5);
    check("a5_rxvalid", bus.rxvalid, 1);
    check("a5_no_error", err_pulses, 0);
    ack_once();
    idle(2);
    check("a5_acked", bus.rxvalid, 0);

    // Start-bit glitch.
    glitch(3);
    check("glitch_rxvalid", bus.rxvalid, 0);
    check("glitch_no_error", err_pulses, 0);

    // Stop bit low then a long break: one error only, then recovery.
    e0 = err_pulses;
    send_frame(8'h3C, 0, N + 50, -1);
    idle(10);
    check("break_one_error", err_pulses - e0, 1);
    check("break_rxvalid", bus.rxvalid, 0);
    send_frame(8'h01, 1, N, -1);
    idle(5);
    check("after_break_rxdata", bus.rxdata, 8'h01);
    ack_once();
    idle(2);

    // Overrun: second byte dropped, then cleared by ack.
    send_frame(8'h11, 1, N, -1);
    send_frame(8'h22, 1, N, -1);
    idle(5);
    check("ovr_rxdata", bus.rxdata, 8'h11);
    check("ovr_flag", bus.overrun, 1);
    ack_once();
    check("ovr_cleared_valid", bus.rxvalid, 0);
    check("ovr_cleared_flag", bus.overrun, 0);
    idle(3);

    // Ack on the exact delivery cycle of the next byte.
    send_frame(8'h11, 1, N, -1);
    idle(5);
    ack_at = cyc + 1 + 2 + H + 9 * N;
    send_frame(8'h22, 1, N, -1);
    idle(3);
    check("sameack_rxdata", bus.rxdata, 8'h22);
    check("sameack_rxvalid", bus.rxvalid, 1);
    check("sameack_overrun", bus.overrun, 0);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'h5A, 1, N, 4);
    @(negedge clock);
    check("post_reset_rxvalid", bus.rxvalid, 0);
    check("post_reset_rxdata", bus.rxdata, 0);
    idle(5);
    send_frame(8'hFF, 1, N, -1);
    idle(5);
    check("ff_rxdata", bus.rxdata, 8'hFF);
    ack_once();
    idle(3);

    // Randomized traffic: short stop bits, glitches, framing errors, random acks.
    ack_rand = 1;
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom % 8;
      if (r == 0) begin
        glitch(1 + $urandom % H);
      end else if (r == 1) begin
        b = 8'($urandom);
        send_frame(b, 0, N + $urandom % 30, -1);
        idle(3 + $urandom % 5);
      end else begin
        b = 8'($urandom);
        if ($urandom % 2 == 0) send_frame(b, 1, N, -1);
        else send_frame(b, 1, H + 3 + $urandom % (N - H - 2), -1);
        idle($urandom % 6);
      end
    end
    ack_rand = 0;
    idle(12 * N);
    check("queue_drained", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
